// File: rtl/cf_pkg.sv
// ============================================================================
// Module      : cf_pkg
// Description : Shared types and constants for the complex_filter frame
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } cf_state_t;

    localparam int FRAME_LEN_DEF = 1024;

    // Width of a counter that holds 0 .. frame_len-1, never narrower than 1.
    function automatic int cnt_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

    localparam int CNT_W = cnt_width(FRAME_LEN_DEF);

endpackage

`default_nettype wire

// File: rtl/cf_pair_oreg.sv
// ============================================================================
// Module      : cf_pair_oreg
// Description : One-slot output register feeding two AXI-Stream masters that
//               share a beat; each port retires independently.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cf_pair_oreg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic              i_last,
    output logic              o_can_load,
    output logic [DATA_W-1:0] o_m00_tdata,
    output logic              o_m00_tvalid,
    output logic              o_m00_tlast,
    input  logic              i_m00_tready,
    output logic [DATA_W-1:0] o_m01_tdata,
    output logic              o_m01_tvalid,
    output logic              o_m01_tlast,
    input  logic              i_m01_tready
);

    logic              r_valid;
    logic              r_taken0;
    logic              r_taken1;
    logic              r_last;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;

    logic w_done0;
    logic w_done1;

    // A port counts as done once it has taken the beat or is taking it now.
    always_comb begin
        w_done0    = r_taken0 | i_m00_tready;
        w_done1    = r_taken1 | i_m01_tready;
        o_can_load = ~r_valid | (w_done0 & w_done1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_taken0 <= 1'b0;
            r_taken1 <= 1'b0;
            r_last   <= 1'b0;
            r_data0  <= '0;
            r_data1  <= '0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_taken0 <= 1'b0;
            r_taken1 <= 1'b0;
            r_last   <= i_last;
            r_data0  <= i_data0;
            r_data1  <= i_data1;
        end else if (r_valid) begin
            if (w_done0 && w_done1) begin
                r_valid  <= 1'b0;
                r_taken0 <= 1'b0;
                r_taken1 <= 1'b0;
            end else begin
                r_taken0 <= w_done0;
                r_taken1 <= w_done1;
            end
        end
    end

    assign o_m00_tdata  = r_data0;
    assign o_m00_tvalid = r_valid & ~r_taken0;
    assign o_m00_tlast  = r_last;
    assign o_m01_tdata  = r_data1;
    assign o_m01_tvalid = r_valid & ~r_taken1;
    assign o_m01_tlast  = r_last;

endmodule

`default_nettype wire

// File: rtl/cf_frame_sched.sv
// ============================================================================
// Module      : cf_frame_sched
// Description : Joins the data and reference streams beat-for-beat, rebuilds
//               frame tlast, counts frames and flushes misaligned streams.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cf_frame_sched
    import cf_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int FCNT_W    = 16
) (
    input  logic              s00_axis_aclk,
    input  logic              s00_axis_aresetn,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic [FCNT_W-1:0] ctrl_num_frames,
    input  logic [DATA_W-1:0] s00_axis_tdata,
    input  logic              s00_axis_tvalid,
    input  logic              s00_axis_tlast,
    output logic              s00_axis_tready,
    input  logic [DATA_W-1:0] s01_axis_tdata,
    input  logic              s01_axis_tvalid,
    input  logic              s01_axis_tlast,
    output logic              s01_axis_tready,
    output logic [DATA_W-1:0] m00_axis_tdata,
    output logic              m00_axis_tvalid,
    output logic              m00_axis_tlast,
    input  logic              m00_axis_tready,
    output logic [DATA_W-1:0] m01_axis_tdata,
    output logic              m01_axis_tvalid,
    output logic              m01_axis_tlast,
    input  logic              m01_axis_tready,
    output logic              sts_busy,
    output logic              sts_done,
    output logic              sts_err_align,
    output logic [FCNT_W-1:0] sts_frames
);

    localparam int                SCNT_W     = cnt_width(FRAME_LEN);
    localparam logic [SCNT_W-1:0] C_LAST_POS = SCNT_W'(FRAME_LEN - 1);
    localparam logic [SCNT_W-1:0] C_SCNT_ONE = SCNT_W'(1);
    localparam logic [FCNT_W:0]   C_FCNT_ONE = (FCNT_W + 1)'(1);

    cf_state_t         r_state;
    logic [SCNT_W-1:0] r_scnt;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] r_num;
    logic              r_stop_req;
    logic              r_fin;
    logic              r_pend00;
    logic              r_pend01;
    logic              r_err;
    logic              r_done;

    logic              w_can_load;
    logic              w_fire;
    logic              w_at_end;
    logic              w_mis;
    logic              w_close;
    logic              w_stop_now;
    logic              w_fin_now;
    logic              w_p00_nxt;
    logic              w_p01_nxt;
    logic [FCNT_W:0]   w_fcnt_inc;

    always_comb begin
        w_fire     = (r_state == RUN) & s00_axis_tvalid & s01_axis_tvalid & w_can_load;
        w_at_end   = (r_scnt == C_LAST_POS);
        // Both tlasts must agree with the regenerated boundary, else the frame closes early.
        w_mis      = (s00_axis_tlast != w_at_end) | (s01_axis_tlast != w_at_end);
        w_close    = w_at_end | w_mis;
        w_fcnt_inc = {1'b0, r_fcnt} + C_FCNT_ONE;
        w_stop_now = r_stop_req | ctrl_stop;
        w_fin_now  = ((r_num != '0) && (w_fcnt_inc == {1'b0, r_num})) | w_stop_now;
        w_p00_nxt  = r_pend00 & ~((r_state == FLUSH) & s00_axis_tvalid & s00_axis_tlast);
        w_p01_nxt  = r_pend01 & ~((r_state == FLUSH) & s01_axis_tvalid & s01_axis_tlast);
    end

    assign s00_axis_tready = w_fire | ((r_state == FLUSH) & r_pend00);
    assign s01_axis_tready = w_fire | ((r_state == FLUSH) & r_pend01);

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_state    <= IDLE;
            r_scnt     <= '0;
            r_fcnt     <= '0;
            r_num      <= '0;
            r_stop_req <= 1'b0;
            r_fin      <= 1'b0;
            r_pend00   <= 1'b0;
            r_pend01   <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ctrl_start) begin
                        r_state    <= RUN;
                        r_num      <= ctrl_num_frames;
                        r_fcnt     <= '0;
                        r_scnt     <= '0;
                        r_err      <= 1'b0;
                        r_stop_req <= 1'b0;
                        r_fin      <= 1'b0;
                        r_pend00   <= 1'b0;
                        r_pend01   <= 1'b0;
                    end
                end
                RUN: begin
                    if (ctrl_stop) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_fire) begin
                        if (w_close) begin
                            r_scnt <= '0;
                            if (!(&r_fcnt)) begin
                                r_fcnt <= w_fcnt_inc[FCNT_W-1:0];
                            end
                            if (w_mis) begin
                                r_err <= 1'b1;
                            end
                            // Early tlast on both streams leaves them aligned; only a lagging one needs flushing.
                            if (w_mis && !(s00_axis_tlast && s01_axis_tlast)) begin
                                r_state  <= FLUSH;
                                r_pend00 <= ~s00_axis_tlast;
                                r_pend01 <= ~s01_axis_tlast;
                                r_fin    <= w_fin_now;
                            end else if (w_fin_now) begin
                                r_state    <= IDLE;
                                r_done     <= 1'b1;
                                r_stop_req <= 1'b0;
                            end
                        end else begin
                            r_scnt <= r_scnt + C_SCNT_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (ctrl_stop) begin
                        r_stop_req <= 1'b1;
                    end
                    r_pend00 <= w_p00_nxt;
                    r_pend01 <= w_p01_nxt;
                    if (!w_p00_nxt && !w_p01_nxt) begin
                        if (r_fin || w_stop_now) begin
                            r_state    <= IDLE;
                            r_done     <= 1'b1;
                            r_stop_req <= 1'b0;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sts_busy      = (r_state != IDLE);
    assign sts_done      = r_done;
    assign sts_err_align = r_err;
    assign sts_frames    = r_fcnt;

    cf_pair_oreg #(
        .DATA_W (DATA_W)
    ) u_oreg (
        .clk          (s00_axis_aclk),
        .rst_n        (s00_axis_aresetn),
        .i_load       (w_fire),
        .i_data0      (s00_axis_tdata),
        .i_data1      (s01_axis_tdata),
        .i_last       (w_close),
        .o_can_load   (w_can_load),
        .o_m00_tdata  (m00_axis_tdata),
        .o_m00_tvalid (m00_axis_tvalid),
        .o_m00_tlast  (m00_axis_tlast),
        .i_m00_tready (m00_axis_tready),
        .o_m01_tdata  (m01_axis_tdata),
        .o_m01_tvalid (m01_axis_tvalid),
        .o_m01_tlast  (m01_axis_tlast),
        .i_m01_tready (m01_axis_tready)
    );

endmodule

`default_nettype wire
